// File: rtl/jt1943_obj_pkg.sv
// Shared constants, phase/state encodings and pixel helpers for the object line buffer.
package jt1943_obj_pkg;

    localparam logic [3:0] TRANSP_NIB = 4'hf;
    localparam logic [7:0] BLANK_PXL  = 8'h0f;
    localparam int         LINE_AW    = 8;

    // Position inside one 6 MHz pixel slot; PH_LATCH is the clk carrying cen6.
    typedef enum logic [1:0] {
        PH_LATCH = 2'd0,
        PH_READ  = 2'd1,
        PH_WRITE = 2'd2,
        PH_ERASE = 2'd3
    } phase_t;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Only the low nibble decides transparency; the palette bits ride along.
    function automatic logic is_transp(input logic [7:0] pxl, input logic [3:0] nib);
        return (pxl & 8'h0f) == {4'h0, nib};
    endfunction

endpackage

// File: rtl/jt1943_objlinebuf_if.sv
// Drawer/mixer side signals of the object line buffer, bundled for the top-level port.
interface jt1943_objlinebuf_if #(
    parameter int AW = 8
);
    logic          cen6;
    logic          LHBL;
    logic [AW-1:0] hpos;
    logic [AW:0]   posx;
    logic [7:0]    new_pxl;
    logic [7:0]    obj_pxl;
    logic          clr_busy;

    modport master (
        output cen6, LHBL, hpos, posx, new_pxl,
        input  obj_pxl, clr_busy
    );

    modport slave (
        input  cen6, LHBL, hpos, posx, new_pxl,
        output obj_pxl, clr_busy
    );
endinterface

// File: rtl/jt1943_lbuf_ram.sv
// True dual-port synchronous RAM, read-first, 1-clk read latency on both ports.
module jt1943_lbuf_ram #(
    parameter int AW = 9,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] din_a,
    input  logic          we_a,
    output logic [DW-1:0] q_a,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] din_b,
    input  logic          we_b,
    output logic [DW-1:0] q_b
);

    logic [DW-1:0] mem [2**AW];

    // NOTE: no reset on the array; the owner clears it through the write ports instead.
    always_ff @(posedge clk) begin
        if (we_a) mem[addr_a] <= din_a;
        if (we_b) mem[addr_b] <= din_b;
        q_a <= mem[addr_a];
        q_b <= mem[addr_b];
    end

endmodule

// File: rtl/jt1943_objlinebuf.sv
// Double-buffered object line buffer: composes the drawer stream into one bank while the
// other bank is played back to the mixer and erased behind the read.
module jt1943_objlinebuf
    import jt1943_obj_pkg::*;
#(
    parameter logic [3:0] TRANSP = TRANSP_NIB,
    parameter int         AW     = LINE_AW
) (
    input  logic clk,
    input  logic rst_n,
    jt1943_objlinebuf_if.slave bus
);

    state_t      state, state_nx;
    logic [AW:0] clr_cnt;
    phase_t      ph_q, ph;
    logic        wrbank;
    logic        lhbl_last;

    logic [AW:0] a_addr_q, b_addr_q;
    logic [7:0]  a_pxl_q;
    logic        a_valid_q, b_valid_q;
    logic [7:0]  hold_q, obj_q;

    logic [AW:0] addr_a;
    logic [7:0]  din_a, q_a, q_b;
    logic        we_a, we_b;

    // The cen6 clk is always phase 0, so the counter only has to run between enables.
    assign ph = bus.cen6 ? PH_LATCH : ph_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_q      <= PH_LATCH;
            lhbl_last <= 1'b1;
        end else begin
            ph_q <= bus.cen6 ? PH_READ : phase_t'(ph_q + 2'd1);
            if (bus.cen6) lhbl_last <= bus.LHBL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_nx = state;
        addr_a   = a_addr_q;
        din_a    = a_pxl_q;
        we_a     = 1'b0;
        we_b     = 1'b0;
        case (state)
            CLEAR: begin
                addr_a = clr_cnt;
                din_a  = BLANK_PXL;
                we_a   = 1'b1;
                if (clr_cnt == '1) state_nx = RUN;
            end
            RUN: begin
                // First opaque pixel wins: only a still-transparent slot may be overwritten.
                we_a = (ph == PH_WRITE) && a_valid_q && is_transp(q_a, TRANSP);
                we_b = (ph == PH_ERASE) && b_valid_q;
            end
            default: state_nx = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrbank    <= 1'b0;
            a_addr_q  <= '0;
            b_addr_q  <= '0;
            a_pxl_q   <= BLANK_PXL;
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
            hold_q    <= BLANK_PXL;
            obj_q     <= BLANK_PXL;
        end else if (state == RUN) begin
            if (ph == PH_LATCH) begin
                // Bank bits are captured here so a swap on this edge leaves these ops untouched.
                a_addr_q  <= {wrbank, bus.posx[AW-1:0]};
                a_pxl_q   <= bus.new_pxl;
                a_valid_q <= !bus.posx[AW] && !is_transp(bus.new_pxl, TRANSP);
                b_addr_q  <= {~wrbank, bus.hpos};
                b_valid_q <= 1'b1;
                if (bus.LHBL) obj_q <= hold_q;
                if (lhbl_last && !bus.LHBL) wrbank <= ~wrbank;
            end
            if (ph == PH_WRITE && b_valid_q) hold_q <= q_b;
        end
    end

    assign bus.obj_pxl  = obj_q;
    assign bus.clr_busy = (state == CLEAR);

    jt1943_lbuf_ram #(
        .AW (AW + 1),
        .DW (8)
    ) u_ram (
        .clk    (clk),
        .addr_a (addr_a),
        .din_a  (din_a),
        .we_a   (we_a & rst_n),
        .q_a    (q_a),
        .addr_b (b_addr_q),
        .din_b  (BLANK_PXL),
        .we_b   (we_b & rst_n),
        .q_b    (q_b)
    );

endmodule

// File: tb/tb_jt1943_objlinebuf.sv
// Self-checking bench: directed lines plus random draws against a two-bank line model.
module tb_jt1943_objlinebuf;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    jt1943_objlinebuf_if bus ();

    jt1943_objlinebuf dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks    = 0;
    int errors    = 0;
    int busy_clks = 0;

    // Reference model: two 256-pixel banks, indexed by the current write-bank bit.
    logic [7:0] mbank [2][256];
    logic       mwb, m_last_lb;
    logic [7:0] rd_prev, exp_obj, obs;

    logic [8:0] dpx   [256];
    logic [7:0] dpl   [256];
    logic [7:0] shown [256];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic reset_model();
        for (int b = 0; b < 2; b++)
            for (int h = 0; h < 256; h++) mbank[b][h] = 8'h0f;
        mwb       = 1'b0;
        m_last_lb = 1'b1;
        rd_prev   = 8'h0f;
        exp_obj   = 8'h0f;
    endtask

    // One 6 MHz pixel: four clks, cen6 on the first, inputs driven on the falling edge.
    task automatic pixel(input logic [8:0] px, input logic [7:0] pxl, input logic [7:0] hp,
                         input logic lb, input bit rst_mid);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rst_n && bus.clr_busy) busy_clks++;
            if (i == 1) begin
                obs = bus.obj_pxl;
                check("obj_pxl", 32'(obs), 32'(exp_obj));
            end
            if (i == 2 && rst_mid) rst_n = 1'b0;
            bus.cen6 = (i == 0);
            if (i == 0) begin
                bus.posx    = px;
                bus.new_pxl = pxl;
                bus.hpos    = hp;
                bus.LHBL    = lb;
                if (lb) exp_obj = rd_prev;
                rd_prev          = mbank[!mwb][hp];
                mbank[!mwb][hp]  = 8'h0f;
                if (!px[8] && pxl[3:0] != 4'hf && mbank[mwb][px[7:0]][3:0] == 4'hf)
                    mbank[mwb][px[7:0]] = pxl;
                if (m_last_lb && !lb) mwb = !mwb;
                m_last_lb = lb;
            end
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2;
        rst_n     = 1'b1;
        busy_clks = 0;
        reset_model();
    endtask

    task automatic wait_clear();
        for (int k = 0; k < 130; k++) pixel(9'h1ff, 8'h0f, 8'd0, 1'b1, 1'b0);
        check("clr_busy_clks", 32'(busy_clks), 32'd512);
        check("clr_busy_end", 32'(bus.clr_busy), 32'd0);
    endtask

    // Visible sweep of 256 pixels, then 8 blank pixels; the first blank one carries bpx/bpl.
    task automatic line(input logic [8:0] bpx, input logic [7:0] bpl);
        for (int h = 0; h < 256; h++) begin
            pixel(dpx[h], dpl[h], 8'(h), 1'b1, 1'b0);
            if (h > 0) shown[h-1] = obs;
        end
        pixel(bpx, bpl, 8'd255, 1'b0, 1'b0);
        for (int k = 1; k < 8; k++) pixel(9'h1ff, 8'h0f, 8'd255, 1'b0, 1'b0);
        for (int h = 0; h < 256; h++) begin
            dpx[h] = 9'h1ff;
            dpl[h] = 8'h0f;
        end
    endtask

    task automatic check_all_blank(input string tag);
        int bad;
        bad = 0;
        for (int h = 0; h < 255; h++) if (shown[h] !== 8'h0f) bad++;
        check(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        bus.cen6    = 1'b0;
        bus.LHBL    = 1'b1;
        bus.posx    = 9'h1ff;
        bus.new_pxl = 8'h0f;
        bus.hpos    = 8'd0;
        for (int h = 0; h < 256; h++) begin
            dpx[h]   = 9'h1ff;
            dpl[h]   = 8'h0f;
            shown[h] = 8'h0f;
        end
        reset_model();

        pixel(9'h1ff, 8'h0f, 8'd0, 1'b1, 1'b0);
        pixel(9'h1ff, 8'h0f, 8'd0, 1'b1, 1'b0);
        check("rst_clr_busy", 32'(bus.clr_busy), 32'd1);
        check("rst_obj_pxl", 32'(bus.obj_pxl), 32'h0f);
        release_reset();
        wait_clear();

        line(9'h1ff, 8'h0f);
        check_all_blank("bank1_blank");
        line(9'h1ff, 8'h0f);
        check_all_blank("bank0_blank");

        dpx[50] = 9'd40;
        dpl[50] = 8'h23;
        line(9'h1ff, 8'h0f);
        line(9'h1ff, 8'h0f);
        check("draw40_hit", 32'(shown[40]), 32'h23);
        check("draw40_left", 32'(shown[39]), 32'h0f);
        check("draw40_right", 32'(shown[41]), 32'h0f);
        line(9'h1ff, 8'h0f);
        check("erase40_n2", 32'(shown[40]), 32'h0f);
        line(9'h1ff, 8'h0f);
        check("erase40_n3", 32'(shown[40]), 32'h0f);

        dpx[3] = 9'd100; dpl[3] = 8'h51;
        dpx[7] = 9'd100; dpl[7] = 8'h62;
        line(9'h1ff, 8'h0f);
        line(9'h1ff, 8'h0f);
        check("first_wins", 32'(shown[100]), 32'h51);

        dpx[20] = 9'd60;   dpl[20] = 8'h7f;
        dpx[21] = 9'h1a0;  dpl[21] = 8'h55;
        line(9'h1ff, 8'h0f);
        line(9'h1ff, 8'h0f);
        check_all_blank("invalid_draws");

        line(9'd10, 8'h34);
        line(9'h1ff, 8'h0f);
        check("swap_edge_draw", 32'(shown[10]), 32'h34);

        for (int r = 0; r < 4; r++) begin
            for (int h = 0; h < 256; h++) begin
                if ($urandom_range(3) == 0) begin
                    dpx[h] = 9'($urandom_range(511)) & 9'h13f;
                    dpl[h] = 8'($urandom_range(255));
                    if ($urandom_range(3) == 0) dpl[h][3:0] = 4'hf;
                end
            end
            line(9'($urandom_range(511)), 8'($urandom_range(255)));
        end
        line(9'h1ff, 8'h0f);

        pixel(9'd5, 8'h44, 8'd0, 1'b1, 1'b1);
        check("midrst_clr_busy", 32'(bus.clr_busy), 32'd1);
        check("midrst_obj_pxl", 32'(bus.obj_pxl), 32'h0f);
        release_reset();
        wait_clear();
        line(9'h1ff, 8'h0f);
        line(9'h1ff, 8'h0f);
        check("midrst_pos5", 32'(shown[5]), 32'h0f);
        check_all_blank("midrst_blank");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
